// File: rtl/vpu_pkg.sv
// Shared vector-processor definitions: opcodes, ALU function codes, element
// widths, the canonical NOP encoding and the ID-stage instruction decoder.
package vpu_pkg;

   typedef enum logic [5:0] {
      OP_LOAD  = 6'b100000,
      OP_STORE = 6'b100001,
      OP_BEZ   = 6'b100010,
      OP_BNZ   = 6'b100011,
      OP_R_ALU = 6'b101010,
      OP_NOP   = 6'b111100
   } opcode_e;

   typedef enum logic [5:0] {
      VNOP   = 6'b000000, VAND, VOR, VXOR, VNOT, VMOV, VADD, VSUB,
      VMULEU = 6'b001000, VMULOU,
      VSLL   = 6'b001010, VSRL, VSRA, VRTTH, VDIV, VMOD,
      VSQEU  = 6'b010000, VSQOU,
      VSQRT  = 6'b010010
   } func_e;

   typedef enum logic [1:0] {
      Width_8  = 2'b00,
      Width_16 = 2'b01,
      Width_32 = 2'b10,
      Width_64 = 2'b11
   } width_e;

   // Bubble / squashed-instruction encoding: NOP opcode, every other field zero.
   localparam logic [0:31] NOP_INSTR = {OP_NOP, 26'd0};

   // Legality plus which register fields the instruction actually reads.
   typedef struct packed {
      logic legal;
      logic use_ra;
      logic use_rb;
      logic use_rd;
   } decode_t;

   function automatic decode_t decode_instr(input logic [0:31] instr);
      decode_t    d;
      logic [5:0] op;
      logic [5:0] fn;
      logic [1:0] ww;
      logic       double_width;
      op = instr[0:5];
      ww = instr[24:25];
      fn = instr[26:31];
      // Widening multiplies/squares have no 128-bit result, so 64-bit elements are rejected.
      double_width = (fn == VMULEU) || (fn == VMULOU) || (fn == VSQEU) || (fn == VSQOU);
      d = '0;
      case (op)
         OP_R_ALU: begin
            d.legal  = (fn <= VSQRT) && !(double_width && (ww == Width_64));
            d.use_ra = d.legal;
            d.use_rb = d.legal;
         end
         OP_LOAD: begin
            d.legal  = 1'b1;
            d.use_ra = 1'b1;
         end
         OP_STORE: begin
            d.legal  = 1'b1;
            d.use_ra = 1'b1;
            d.use_rd = 1'b1;
         end
         OP_BEZ, OP_BNZ: begin
            d.legal  = 1'b1;
            d.use_rd = 1'b1;
         end
         OP_NOP:  d.legal = 1'b1;
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/vreg_file.sv
// 32 x 64 vector register file: three combinational read ports, one write
// port, register 0 hard-wired to zero, write-through bypass on reads.
module vreg_file
   import vpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        we_i,
   input  logic [0:4]  waddr_i,
   input  logic [0:63] wdata_i,
   input  logic [0:4]  ra_addr_i,
   input  logic [0:4]  rb_addr_i,
   input  logic [0:4]  rd_addr_i,
   output logic [0:63] ra_data_o,
   output logic [0:63] rb_data_o,
   output logic [0:63] rd_data_o
);

   logic [0:63] regs_q [32];

   // A read that collides with this cycle's writeback sees the new data.
   function automatic logic [0:63] read_port(input logic [0:4] addr);
      if (addr == '0)
         return '0;
      else if (we_i && (addr == waddr_i))
         return wdata_i;
      else
         return regs_q[addr];
   endfunction

   // Writeback storage; register 0 is never written.
   // NOTE: this array is reset on purpose (architectural state must be zero out
   // of reset), which forces flops rather than a RAM macro.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Three independent combinational read ports.
   always_comb begin
      ra_data_o = read_port(ra_addr_i);
      rb_data_o = read_port(rb_addr_i);
      rd_data_o = read_port(rd_addr_i);
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: decodes and legality-checks the
// fetched instruction, reads operands, detects load-use hazards and applies
// flush > stall > load-use > advance priority.
module id_ex_stage
   import vpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [0:31] IF_ID_Instr,
   input  logic        IF_ID_Valid,
   input  logic        EX_Stall,
   input  logic        EX_Flush,
   input  logic        WB_WrEn,
   input  logic [0:4]  WB_WrAddr,
   input  logic [0:63] WB_WrData,
   output logic [0:31] ID_EX_Instr,
   output logic [0:63] ID_EX_rA_data,
   output logic [0:63] ID_EX_rB_data,
   output logic [0:63] ID_EX_rD_data,
   output logic        ID_EX_Valid,
   output logic        ID_Stall,
   output logic        ID_Illegal
);

   logic [0:31] instr_q, instr_d;
   logic [0:63] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
   logic        valid_q, valid_d;
   logic        illegal_q, illegal_d;

   logic [0:4]  if_ra, if_rb, if_rd, ex_rd;
   logic [0:63] ra_rdata, rb_rdata, rd_rdata;
   decode_t     dec;
   logic        ex_is_load, load_use;

   assign if_rd = IF_ID_Instr[6:10];
   assign if_ra = IF_ID_Instr[11:15];
   assign if_rb = IF_ID_Instr[16:20];
   assign ex_rd = instr_q[6:10];
   assign dec   = decode_instr(IF_ID_Instr);

   vreg_file u_vreg_file (
      .clk       (clk),
      .reset_n   (reset_n),
      .we_i      (WB_WrEn),
      .waddr_i   (WB_WrAddr),
      .wdata_i   (WB_WrData),
      .ra_addr_i (if_ra),
      .rb_addr_i (if_rb),
      .rd_addr_i (if_rd),
      .ra_data_o (ra_rdata),
      .rb_data_o (rb_rdata),
      .rd_data_o (rd_rdata)
   );

   // A load in EX whose destination is read by the decoding instruction.
   assign ex_is_load = valid_q && (instr_q[0:5] == OP_LOAD) && (ex_rd != '0);
   assign load_use   = ex_is_load && IF_ID_Valid &&
                       ((dec.use_ra && (if_ra == ex_rd)) ||
                        (dec.use_rb && (if_rb == ex_rd)) ||
                        (dec.use_rd && (if_rd == ex_rd)));

   // Fetch holds while EX is stalled or a load-use bubble is inserted; a flush overrides.
   assign ID_Stall = !EX_Flush && (EX_Stall || load_use);

   // Next ID/EX contents in priority order.
   always_comb begin
      // NOTE: every output takes a hold value first so no path leaves one unassigned (no latch).
      instr_d   = instr_q;
      valid_d   = valid_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      rd_d      = rd_q;
      illegal_d = 1'b0;
      if (EX_Flush || (!EX_Stall && (load_use || !IF_ID_Valid))) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         ra_d    = '0;
         rb_d    = '0;
         rd_d    = '0;
      end else if (!EX_Stall) begin
         valid_d = 1'b1;
         if (!dec.legal) begin
            instr_d   = NOP_INSTR;
            ra_d      = '0;
            rb_d      = '0;
            rd_d      = '0;
            illegal_d = 1'b1;
         end else begin
            instr_d = IF_ID_Instr;
            ra_d    = dec.use_ra ? ra_rdata : '0;
            rb_d    = dec.use_rb ? rb_rdata : '0;
            rd_d    = dec.use_rd ? rd_rdata : '0;
         end
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_q   <= NOP_INSTR;
         valid_q   <= 1'b0;
         ra_q      <= '0;
         rb_q      <= '0;
         rd_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values together.
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         rd_q      <= rd_d;
         illegal_q <= illegal_d;
      end
   end

   assign ID_EX_Instr   = instr_q;
   assign ID_EX_Valid   = valid_q;
   assign ID_EX_rA_data = ra_q;
   assign ID_EX_rB_data = rb_q;
   assign ID_EX_rD_data = rd_q;
   assign ID_Illegal    = illegal_q;

endmodule
